ddr_rd_burst_arbiter: RTL and testbench

//  Shares the single DDR read-burst port among NUM_REQ weight-FIFO fetchers (Q, K, V, MLP).

---
 rtl/ddr_rd_burst_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ddr_rd_burst_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_arbiter.sv
// ============================================================================
// Module   : ddr_rd_burst_arbiter
// Brief    : Round-robin, burst-granular arbiter sharing one DDR read-burst
//            port among NUM_REQ weight fetchers. Optional watchdog enabled by
//            defining DDR_ARB_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_rd_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                                  s_clk,
    input  logic                                  s_rst,
    input  logic [NUM_REQ-1:0]                    s_rd_burst_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]          s_rd_burst_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]          s_rd_burst_len,
    output logic [DATA_WIDTH-1:0]                 s_rd_burst_data,
    output logic [NUM_REQ-1:0]                    s_rd_burst_valid,
    output logic [NUM_REQ-1:0]                    s_rd_burst_finish,
    output logic                                  m_rd_burst_req,
    output logic [ADDR_SIZE-1:0]                  m_rd_burst_addr,
    output logic [LEN_WIDTH-1:0]                  m_rd_burst_len,
    input  logic [DATA_WIDTH-1:0]                 m_rd_burst_data,
    input  logic                                  m_rd_burst_valid,
    input  logic                                  m_rd_burst_finish,
    output logic [(NUM_REQ>1?$clog2(NUM_REQ):1)-1:0] o_grant_id,
    output logic                                  o_busy,
    output logic                                  o_wdt_err
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [ADDR_SIZE-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH-1:0] len_q,   len_d;
    logic                 mreq_q,  mreq_d;
    logic                 busy;
    logic                 found;
    logic [GW-1:0]        sel;

    // Circular search starting one past the last grant gives rotating priority
    always_comb begin
        found = 1'b0;
        sel   = grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && s_rd_burst_req[idx]) begin
                found = 1'b1;
                sel   = idx[GW-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_BURST;
            end
            ST_BURST: begin
                if (m_rd_burst_finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic
    always_comb begin
        busy   = (state_q != ST_IDLE);
        mreq_d = (state_q == ST_GRANT) ||
                 ((state_q == ST_BURST) && !m_rd_burst_finish);
    end

    // Grant, address and length are captured only at arbitration time
    always_comb begin
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        if ((state_q == ST_IDLE) && found) begin
            grant_d = sel;
            addr_d  = s_rd_burst_addr[sel*ADDR_SIZE +: ADDR_SIZE];
            len_d   = s_rd_burst_len[sel*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            grant_q <= LAST_ID;
            addr_q  <= '0;
            len_q   <= '0;
            mreq_q  <= 1'b0;
        end else begin
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            mreq_q  <= mreq_d;
        end
    end

    assign m_rd_burst_req  = mreq_q;
    assign m_rd_burst_addr = addr_q;
    assign m_rd_burst_len  = len_q;
    assign o_grant_id      = grant_q;
    assign o_busy          = busy;
    assign s_rd_burst_data = m_rd_burst_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_demux
        assign s_rd_burst_valid[i]  = m_rd_burst_valid  & busy & (grant_q == GW'(i));
        assign s_rd_burst_finish[i] = m_rd_burst_finish & busy & (grant_q == GW'(i));
    end

`ifdef DDR_ARB_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES + 1);

    logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_err_q, wdt_err_d;

    // Counter saturates at the limit; the error is sticky and never aborts the burst
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        wdt_err_d = wdt_err_q;
        if (state_q == ST_GRANT) begin
            wdt_cnt_d = '0;
        end else if ((state_q == ST_BURST) && (wdt_cnt_q != CW'(WDT_CYCLES))) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
        if ((state_q == ST_BURST) && !m_rd_burst_finish &&
            (wdt_cnt_q == CW'(WDT_CYCLES - 1))) begin
            wdt_err_d = 1'b1;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_d;
        end
    end

    assign o_wdt_err = wdt_err_q;
`else
    assign o_wdt_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_rd_burst_arbiter.sv
// ============================================================================
// Module   : tb_ddr_rd_burst_arbiter
// Brief    : Randomized self-checking bench for ddr_rd_burst_arbiter against a
//            round-robin reference model; watchdog checks follow DDR_ARB_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_rd_burst_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int LW  = 10;
    localparam int WDT = 64;

    logic              s_clk = 1'b0;
    logic              s_rst;
    logic [NR-1:0]     s_req;
    logic [NR*AW-1:0]  s_addr;
    logic [NR*LW-1:0]  s_len;
    logic [DW-1:0]     s_data;
    logic [NR-1:0]     s_valid;
    logic [NR-1:0]     s_finish;
    logic              m_req;
    logic [AW-1:0]     m_addr;
    logic [LW-1:0]     m_len;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_finish;
    logic [1:0]        gid;
    logic              busy;
    logic              wdt_err;

    int checks = 0;
    int errors = 0;
    int last   = NR - 1;

    logic [AW-1:0] addr_v [NR];
    logic [LW-1:0] len_v  [NR];

    ddr_rd_burst_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_SIZE  (AW),
        .LEN_WIDTH  (LW),
        .WDT_CYCLES (WDT)
    ) dut (
        .s_clk             (s_clk),
        .s_rst             (s_rst),
        .s_rd_burst_req    (s_req),
        .s_rd_burst_addr   (s_addr),
        .s_rd_burst_len    (s_len),
        .s_rd_burst_data   (s_data),
        .s_rd_burst_valid  (s_valid),
        .s_rd_burst_finish (s_finish),
        .m_rd_burst_req    (m_req),
        .m_rd_burst_addr   (m_addr),
        .m_rd_burst_len    (m_len),
        .m_rd_burst_data   (m_data),
        .m_rd_burst_valid  (m_valid),
        .m_rd_burst_finish (m_finish),
        .o_grant_id        (gid),
        .o_busy            (busy),
        .o_wdt_err         (wdt_err)
    );

    always #5 s_clk = ~s_clk;

    // Reference rule: first requester found scanning circularly after the last winner
    function automatic int rr_pick(input logic [NR-1:0] r, input int prev);
        for (int k = 1; k <= NR; k++) begin
            if (r[(prev + k) % NR]) return (prev + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic drive_slices();
        for (int i = 0; i < NR; i++) begin
            s_addr[i*AW +: AW] = addr_v[i];
            s_len[i*LW +: LW]  = len_v[i];
        end
    endtask

    task automatic rand_slices(input int maxlen);
        for (int i = 0; i < NR; i++) begin
            addr_v[i] = $urandom;
            len_v[i]  = LW'($urandom_range(maxlen, 1));
        end
    endtask

    task automatic do_reset();
        s_rst    = 1'b1;
        m_valid  = 1'b0;
        m_finish = 1'b0;
        s_req    = '0;
        step();
        step();
        s_rst = 1'b0;
        last  = NR - 1;
    endtask

    // Runs one full burst from IDLE and checks grant, latency, routing and teardown
    task automatic run_burst(input logic [NR-1:0] req, input int drop_at, input int gap_max);
        int w;
        int n;
        int len;
        logic [DW-1:0] d;
        logic [NR-1:0] oh;
        s_req = req;
        drive_slices();
        w   = rr_pick(req, last);
        oh  = NR'(1 << w);
        len = int'(len_v[w]);
        n = 0;
        while (!m_req && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected 2", n);
        end
        checks++;
        if (gid !== 2'(w)) begin
            errors++;
            $display("FAIL grant_id: got %0d, expected %0d (req=%b)", gid, w, req);
        end
        checks++;
        if (m_addr !== addr_v[w] || m_len !== len_v[w]) begin
            errors++;
            $display("FAIL addr_len: got %h/%0d, expected %h/%0d", m_addr, m_len, addr_v[w], len_v[w]);
        end
        rand_slices(1023);
        drive_slices();
        for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                m_valid = 1'b0;
                #1;
                checks++;
                if (s_valid !== '0) begin
                    errors++;
                    $display("FAIL idle_beat: got %b, expected 0000", s_valid);
                end
                step();
            end
            d       = {$urandom, $urandom};
            m_data  = d;
            m_valid = 1'b1;
            #1;
            checks++;
            if (s_valid !== oh || s_data !== d) begin
                errors++;
                $display("FAIL beat %0d: valid %b data %h, expected %b %h", b, s_valid, s_data, oh, d);
            end
            if (b == drop_at) s_req[w] = 1'b0;
            step();
        end
        checks++;
        if (m_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold: m_req %b busy %b, expected 1 1", m_req, busy);
        end
        m_valid  = 1'b0;
        m_finish = 1'b1;
        #1;
        checks++;
        if (s_finish !== oh) begin
            errors++;
            $display("FAIL finish_route: got %b, expected %b", s_finish, oh);
        end
        step();
        m_finish = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || busy !== 1'b0 || s_finish !== '0) begin
            errors++;
            $display("FAIL teardown: m_req %b busy %b finish %b, expected 0 0 0000", m_req, busy, s_finish);
        end
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== '0) begin
            errors++;
            $display("FAIL idle_drop: got %b, expected 0000", s_valid);
        end
        m_valid = 1'b0;
        last = w;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_req = '0; s_addr = '0; s_len = '0;
        m_data = '0; m_valid = 1'b0; m_finish = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || m_addr !== '0 || m_len !== '0) begin
            errors++;
            $display("FAIL reset_m: req %b addr %h len %0d, expected 0 0 0", m_req, m_addr, m_len);
        end
        checks++;
        if (gid !== 2'd3 || busy !== 1'b0 || wdt_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: gid %0d busy %b wdt %b, expected 3 0 0", gid, busy, wdt_err);
        end
        step();
        step();
        s_rst = 1'b0;
        last  = NR - 1;
    endtask

    task automatic test_single();
        do_reset();
        rand_slices(8);
        addr_v[0] = 32'h0000_1000;
        len_v[0]  = 10'd32;
        run_burst(4'b0001, -1, 0);
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_slices(6);
            run_burst(4'b1111, -1, 1);
            checks++;
            if (gid !== 2'(exp_seq[i])) begin
                errors++;
                $display("FAIL rr_order %0d: got %0d, expected %0d", i, gid, exp_seq[i]);
            end
        end
    endtask

    task automatic test_skip();
        do_reset();
        rand_slices(4);
        run_burst(4'b0010, -1, 0);
        rand_slices(4);
        run_burst(4'b1001, -1, 0);
        checks++;
        if (gid !== 2'd3) begin
            errors++;
            $display("FAIL skip_3: got %0d, expected 3", gid);
        end
        rand_slices(4);
        run_burst(4'b1001, -1, 0);
        checks++;
        if (gid !== 2'd0) begin
            errors++;
            $display("FAIL skip_0: got %0d, expected 0", gid);
        end
    endtask

    task automatic test_drop();
        rand_slices(4);
        len_v[2] = 10'd32;
        run_burst(4'b0100, 10, 0);
        checks++;
        if (gid !== 2'd2 || s_req !== 4'b0000) begin
            errors++;
            $display("FAIL drop: gid %0d req %b, expected 2 0000", gid, s_req);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            rand_slices(16);
            run_burst(NR'($urandom_range(15, 1)), int'($urandom_range(20, 0)), 2);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        rand_slices(8);
        len_v[2] = 10'd32;
        s_req = 4'b0100;
        drive_slices();
        n = 0;
        while (!m_req && n < 10) begin
            step();
            n++;
        end
        for (int b = 0; b < 5; b++) begin
            m_valid = 1'b1;
            m_data  = {$urandom, $urandom};
            step();
        end
        #2;
        s_rst = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b0 || busy !== 1'b0 || gid !== 2'd3) begin
            errors++;
            $display("FAIL async_rst: m_req %b busy %b gid %0d, expected 0 0 3", m_req, busy, gid);
        end
        checks++;
        if (m_addr !== '0 || m_len !== '0 || s_valid !== '0) begin
            errors++;
            $display("FAIL async_rst_data: addr %h len %0d valid %b, expected 0 0 0000", m_addr, m_len, s_valid);
        end
        m_valid = 1'b0;
        step();
        step();
        s_rst = 1'b0;
        last  = NR - 1;
        rand_slices(8);
        run_burst(4'b0100, -1, 0);
        checks++;
        if (gid !== 2'd2) begin
            errors++;
            $display("FAIL post_rst_grant: got %0d, expected 2", gid);
        end
    endtask

    task automatic test_wdt();
        int n;
        logic exp_err;
`ifdef DDR_ARB_WDT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        rand_slices(8);
        s_req = 4'b0001;
        drive_slices();
        n = 0;
        while (!m_req && n < 10) begin
            step();
            n++;
        end
        repeat (WDT - 1) step();
        checks++;
        if (wdt_err !== 1'b0) begin
            errors++;
            $display("FAIL wdt_early: got %b, expected 0", wdt_err);
        end
        step();
        checks++;
        if (wdt_err !== exp_err) begin
            errors++;
            $display("FAIL wdt_limit: got %b, expected %b", wdt_err, exp_err);
        end
        repeat (10) step();
        checks++;
        if (wdt_err !== exp_err || m_req !== 1'b1) begin
            errors++;
            $display("FAIL wdt_wait: err %b m_req %b, expected %b 1", wdt_err, m_req, exp_err);
        end
        m_finish = 1'b1;
        s_req    = '0;
        step();
        m_finish = 1'b0;
        repeat (3) step();
        checks++;
        if (wdt_err !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL wdt_sticky: err %b busy %b, expected %b 0", wdt_err, busy, exp_err);
        end
        last = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_drop();
        test_random();
        test_async_reset();
        test_wdt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
